// File: rtl/dsp_mix_router.sv
// dsp_mix_router: per-sink source selectors plus NDST weighted-sum outputs
// with double-buffered signed gains, a pipelined adder tree and saturation.
module dsp_mix_router #(
  parameter int unsigned NSRC      = 16,
  parameter int unsigned NSINK     = 12,
  parameter int unsigned NDST      = 2,
  parameter int unsigned DW        = 14,
  parameter int unsigned GAIN_W    = 16,
  parameter int unsigned GAIN_FRAC = 14,
  parameter int unsigned SEL_W     = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NSRC*DW-1:0]    src_i,
  output logic [NSINK*DW-1:0]   sink_o,
  output logic [NDST*DW-1:0]    dst_o,
  output logic [NDST-1:0]       sat_o,
  input  logic [31:0]           sys_addr,
  input  logic [31:0]           sys_wdata,
  input  logic                  sys_wen,
  input  logic                  sys_ren,
  output logic [31:0]           sys_rdata,
  output logic                  sys_ack,
  output logic                  sys_err
);

  localparam int unsigned T       = $clog2(NSRC);
  localparam int unsigned PW      = DW + GAIN_W;
  localparam int unsigned AW      = PW + T;
  localparam int unsigned NG      = NDST * NSRC;
  localparam int unsigned SRC_IW  = (NSRC  > 1) ? $clog2(NSRC)  : 1;
  localparam int unsigned SINK_IW = (NSINK > 1) ? $clog2(NSINK) : 1;
  localparam int unsigned GIDX_W  = (NG    > 1) ? $clog2(NG)    : 1;
  localparam int unsigned DIW     = (NDST  > 1) ? $clog2(NDST)  : 1;
  localparam int unsigned PIW     = (GIDX_W > SINK_IW) ? GIDX_W : SINK_IW;
  localparam logic signed [AW-1:0] SAT_MAX = (AW'(1) <<< (DW - 1)) - AW'(1);
  localparam logic signed [AW-1:0] SAT_MIN = -SAT_MAX - AW'(1);

  // configuration state
  logic [SEL_W-1:0]         sel_q    [NSINK];
  logic signed [GAIN_W-1:0] gain_sh  [NG];
  logic signed [GAIN_W-1:0] gain_act [NG];
  logic [NDST-1:0]          sticky_q;

  // bus request registered in the ack cycle, applied on the following edge
  logic                     pend_sel, pend_gain, pend_commit;
  logic [PIW-1:0]           pend_idx;
  logic [GAIN_W-1:0]        pend_data;

  // datapath
  logic signed [DW-1:0]     src_a [NSRC];
  logic signed [DW-1:0]     s0_q  [NSRC];
  logic signed [PW-1:0]     p_q   [NDST][NSRC];
  logic signed [AW-1:0]     tr_q  [NDST][T][NSRC];
  logic signed [AW-1:0]     lin   [NDST][T][2*NSRC];
  logic signed [AW-1:0]     sh;
  logic signed [DW-1:0]     dst_n [NDST];
  logic [NDST-1:0]          sat_n;
  logic signed [DW-1:0]     dst_q [NDST];
  logic [NDST-1:0]          sat_q;
  logic signed [DW-1:0]     sink_q [NSINK];

  // bus decode
  logic [3:0]               page;
  logic [9:0]               widx, didx;
  logic                     hit_sel, hit_gain, hit_commit, hit_status, hit_dst, hit;
  logic [31:0]              rd_val;
  logic [NDST-1:0]          sticky_clr;
  logic                     unused_bits;

  assign unused_bits = &{1'b0, sys_addr[31:16], sys_addr[1:0], sys_wdata[31:GAIN_W]};

  // address decode and read-data mux
  always_comb begin
    page       = sys_addr[15:12];
    widx       = sys_addr[11:2];
    didx       = widx - 10'd2;
    hit_sel    = (page == 4'h0) && (32'(widx) < NSINK);
    hit_gain   = (page == 4'h1) && (32'(widx) < NG);
    hit_commit = (page == 4'h2) && (widx == 10'd0);
    hit_status = (page == 4'h2) && (widx == 10'd1);
    hit_dst    = (page == 4'h2) && (32'(didx) < NDST);
    hit        = hit_sel | hit_gain | hit_commit | hit_status | hit_dst;
    rd_val     = '0;
    if (hit_sel)    rd_val = 32'(sel_q[widx[SINK_IW-1:0]]);
    if (hit_gain)   rd_val = 32'(gain_sh[widx[GIDX_W-1:0]]);
    if (hit_status) rd_val = 32'(sticky_q);
    if (hit_dst)    rd_val = 32'(dst_q[didx[DIW-1:0]]);
    sticky_clr = {NDST{sys_ren & ~sys_wen & hit_status}};
  end

  // bus response, deferred register writes, gain commit and sticky flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sys_ack     <= 1'b0;
      sys_err     <= 1'b0;
      sys_rdata   <= '0;
      pend_sel    <= 1'b0;
      pend_gain   <= 1'b0;
      pend_commit <= 1'b0;
      pend_idx    <= '0;
      pend_data   <= '0;
      sticky_q    <= '0;
      for (int k = 0; k < NSINK; k++) sel_q[k] <= '1;
      for (int g = 0; g < NG; g++) begin
        gain_sh[g]  <= '0;
        gain_act[g] <= '0;
      end
    end else begin
      sys_ack     <= sys_wen | sys_ren;
      sys_err     <= (sys_wen | sys_ren) & ~hit;
      sys_rdata   <= (sys_ren & ~sys_wen & hit) ? rd_val : '0;
      pend_sel    <= sys_wen & hit_sel;
      pend_gain   <= sys_wen & hit_gain;
      pend_commit <= sys_wen & hit_commit;
      pend_idx    <= widx[PIW-1:0];
      pend_data   <= sys_wdata[GAIN_W-1:0];
      if (pend_sel)    sel_q[pend_idx[SINK_IW-1:0]] <= pend_data[SEL_W-1:0];
      if (pend_gain)   gain_sh[pend_idx[GIDX_W-1:0]] <= pend_data;
      if (pend_commit) gain_act <= gain_sh;
      sticky_q    <= (sticky_q & ~sticky_clr) | sat_n;
    end
  end

  // adder-tree level inputs, zero-padded so odd leftovers pass through
  always_comb begin
    for (int d = 0; d < NDST; d++)
      for (int l = 0; l < T; l++)
        for (int j = 0; j < 2*NSRC; j++) lin[d][l][j] = '0;
    for (int d = 0; d < NDST; d++)
      for (int j = 0; j < NSRC; j++) lin[d][0][j] = AW'(p_q[d][j]);
    for (int d = 0; d < NDST; d++)
      for (int l = 1; l < T; l++)
        for (int j = 0; j < NSRC; j++) lin[d][l][j] = tr_q[d][l-1][j];
  end

  // final scaling (floor) and saturation to DW bits
  always_comb begin
    sh    = '0;
    sat_n = '0;
    for (int d = 0; d < NDST; d++) begin
      sh       = tr_q[d][T-1][0] >>> GAIN_FRAC;
      dst_n[d] = DW'(sh);
      if (sh > SAT_MAX) begin
        dst_n[d] = DW'(SAT_MAX);
        sat_n[d] = 1'b1;
      end else if (sh < SAT_MIN) begin
        dst_n[d] = DW'(SAT_MIN);
        sat_n[d] = 1'b1;
      end
    end
  end

  // mix pipeline: source capture, products, tree levels, output stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NSRC; i++) s0_q[i] <= '0;
      for (int d = 0; d < NDST; d++) begin
        for (int i = 0; i < NSRC; i++) p_q[d][i] <= '0;
        for (int l = 0; l < T; l++)
          for (int i = 0; i < NSRC; i++) tr_q[d][l][i] <= '0;
        dst_q[d] <= '0;
      end
      sat_q <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) s0_q[i] <= src_a[i];
      for (int d = 0; d < NDST; d++) begin
        for (int i = 0; i < NSRC; i++)
          p_q[d][i] <= PW'(s0_q[i]) * PW'(gain_act[d*NSRC+i]);
        for (int l = 0; l < T; l++)
          for (int i = 0; i < NSRC; i++)
            tr_q[d][l][i] <= lin[d][l][2*i] + lin[d][l][2*i+1];
        dst_q[d] <= dst_n[d];
      end
      sat_q <= sat_n;
    end
  end

  // unpack sources
  always_comb begin
    for (int i = 0; i < NSRC; i++) src_a[i] = src_i[i*DW +: DW];
  end

  // sink selectors, one cycle from src_i
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NSINK; k++) sink_q[k] <= '0;
    end else begin
      for (int k = 0; k < NSINK; k++)
        sink_q[k] <= (32'(sel_q[k]) >= NSRC) ? '0 : src_a[sel_q[k][SRC_IW-1:0]];
    end
  end

  // pack registered outputs
  always_comb begin
    sink_o = '0;
    dst_o  = '0;
    for (int k = 0; k < NSINK; k++) sink_o[k*DW +: DW] = sink_q[k];
    for (int d = 0; d < NDST; d++) dst_o[d*DW +: DW] = dst_q[d];
    sat_o = sat_q;
  end

endmodule

// File: tb/tb_dsp_mix_router.sv
// Directed bench for dsp_mix_router with hand-computed expectations.
module tb_dsp_mix_router;

  localparam int NSRC  = 16;
  localparam int NSINK = 12;
  localparam int NDST  = 2;
  localparam int DW    = 14;
  localparam int LAT   = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NSRC*DW-1:0]   src;
  logic [NSINK*DW-1:0]  sink_o;
  logic [NDST*DW-1:0]   dst_o;
  logic [NDST-1:0]      sat_o;
  logic [31:0]          addr, wdata, sys_rdata;
  logic                 wen, ren, sys_ack, sys_err;

  logic [31:0]          rd;
  logic                 ack, err;
  int                   n_checks = 0;
  int                   n_pass   = 0;

  always #5 clk = ~clk;

  dsp_mix_router #(
    .NSRC(16), .NSINK(12), .NDST(2), .DW(14),
    .GAIN_W(16), .GAIN_FRAC(14), .SEL_W(5)
  ) dut (
    .clk_i(clk), .rst_i(rst), .src_i(src),
    .sink_o(sink_o), .dst_o(dst_o), .sat_o(sat_o),
    .sys_addr(addr), .sys_wdata(wdata), .sys_wen(wen), .sys_ren(ren),
    .sys_rdata(sys_rdata), .sys_ack(sys_ack), .sys_err(sys_err)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int dst_v(input int d);
    logic signed [DW-1:0] v;
    v = dst_o[d*DW +: DW];
    return int'(v);
  endfunction

  function automatic int sink_v(input int k);
    logic signed [DW-1:0] v;
    v = sink_o[k*DW +: DW];
    return int'(v);
  endfunction

  task automatic set_src(input int s, input int v);
    src[s*DW +: DW] = DW'(v);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
    tick();
    wen = 1'b0;
    tick();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d,
                          output logic a_o, output logic e_o);
    addr = a; ren = 1'b1;
    tick();
    d = sys_rdata; a_o = sys_ack; e_o = sys_err;
    ren = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0; ren = 1'b0; addr = '0; wdata = '0;
    for (int s = 0; s < NSRC; s++) set_src(s, int'($urandom));

    // reset state
    tick(); tick();
    check("rst_dst", int'(dst_o != '0), 0);
    check("rst_sink", int'(sink_o != '0), 0);
    check("rst_sat", int'(sat_o), 0);
    check("rst_ack", int'(sys_ack), 0);
    rst = 1'b0;
    src = '0;
    bus_read(32'h0000, rd, ack, err);
    check("sel0_rst", int'(rd), 'h1f);
    check("sel0_ack", int'(ack), 1);
    bus_read(32'h1000, rd, ack, err);
    check("gain00_rst", int'(rd), 0);
    bus_read(32'h2004, rd, ack, err);
    check("status_rst", int'(rd), 0);

    // shadow gain is inert until commit; then exact latency
    set_src(2, 1000);
    bus_write(32'h1008, 32'h4000);
    repeat (10) tick();
    check("precommit_dst0", dst_v(0), 0);
    set_src(2, 0);
    repeat (10) tick();
    bus_write(32'h2000, 32'h1);
    set_src(2, 1000);
    repeat (LAT-1) tick();
    check("lat_minus1", dst_v(0), 0);
    tick();
    check("lat_dst0", dst_v(0), 1000);
    check("lat_dst1", dst_v(1), 0);
    bus_read(32'h2008, rd, ack, err);
    check("rd_dst0", int'(rd), 1000);

    // positive saturation and sticky read-to-clear
    set_src(2, 0);
    bus_write(32'h1000, 32'h4000);
    bus_write(32'h1004, 32'h4000);
    bus_write(32'h2000, 32'h0);
    set_src(0, 8000); set_src(1, 8000);
    repeat (10) tick();
    check("possat_dst0", dst_v(0), 8191);
    check("possat_flag", int'(sat_o), 1);
    set_src(1, 0);
    repeat (10) tick();
    check("nosat_dst0", dst_v(0), 8000);
    check("nosat_flag", int'(sat_o), 0);
    bus_read(32'h2004, rd, ack, err);
    check("status_first", int'(rd), 1);
    bus_read(32'h2004, rd, ack, err);
    check("status_second", int'(rd), 0);

    // -1.0 * -8192 saturates; 0.5 * -3 floors to -2
    set_src(0, 0);
    bus_write(32'h1050, 32'h0000_C000);
    bus_write(32'h1014, 32'h0000_2000);
    bus_write(32'h2000, 32'h0);
    set_src(4, -8192); set_src(5, -3);
    repeat (10) tick();
    check("negone_dst1", dst_v(1), 8191);
    check("floor_dst0", dst_v(0), -2);
    check("sat_flags", int'(sat_o), 2);
    bus_read(32'h200C, rd, ack, err);
    check("rd_dst1", int'(rd), 8191);
    bus_read(32'h2008, rd, ack, err);
    check("rd_dst0_sext", int'(rd), -2);
    bus_read(32'h1050, rd, ack, err);
    check("rd_gain_sext", int'(rd), -16384);
    bus_read(32'h2004, rd, ack, err);
    check("status_dst1", int'(rd), 2);

    // sink routing, NONE selector, unmapped access, simultaneous rd/wr
    set_src(5, -77);
    bus_write(32'h000C, 32'd5);
    tick();
    check("sink3_src5", sink_v(3), -77);
    set_src(5, 123);
    tick();
    check("sink3_lat1", sink_v(3), 123);
    bus_write(32'h000C, 32'd16);
    tick();
    check("sink3_none", sink_v(3), 0);
    bus_read(32'h3000, rd, ack, err);
    check("unmapped_ack", int'(ack), 1);
    check("unmapped_err", int'(err), 1);
    check("unmapped_rdata", int'(rd), 0);
    addr = 32'h0000; wdata = 32'd7; wen = 1'b1; ren = 1'b1;
    tick();
    check("rw_ack", int'(sys_ack), 1);
    check("rw_rdata", int'(sys_rdata), 0);
    check("rw_err", int'(sys_err), 0);
    wen = 1'b0; ren = 1'b0;
    tick();
    bus_read(32'h0000, rd, ack, err);
    check("rw_sel0", int'(rd), 7);
    bus_read(32'h000C, rd, ack, err);
    check("sel3_rd", int'(rd), 16);
    repeat (LAT) tick();
    check("dst0_half", dst_v(0), 61);

    // mid-stream reset flushes pipeline and clears gains
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_dst0", dst_v(0), 0);
    check("mrst_dst1", dst_v(1), 0);
    check("mrst_sat", int'(sat_o), 0);
    repeat (10) tick();
    check("mrst_hold", int'(dst_o != '0), 0);
    bus_read(32'h000C, rd, ack, err);
    check("mrst_sel3", int'(rd), 'h1f);
    bus_write(32'h1014, 32'h0000_2000);
    repeat (10) tick();
    check("mrst_nocommit", dst_v(0), 0);
    bus_write(32'h2000, 32'h0);
    repeat (10) tick();
    check("mrst_recommit", dst_v(0), 61);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
